// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment multiplexer.
// Segment vectors are active low, ordered {CA,CB,CC,CD,CE,CF,CG} (CA = MSB).
package seg7_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_TO_SEG [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one nibble
    always_comb begin
        seg_o = HEX_TO_SEG[hex_i];
    end

endmodule

// File: rtl/seg7_mux_ctrl.sv
// seg7_mux_ctrl: time-multiplexed driver for NUM_DIGITS common-anode digits
// with per-digit enable, PWM brightness, anti-ghosting blank interval and
// frame-synchronous shadow latching of all display inputs.
// Optional build macro SEG7_LAMP_TEST_EN adds i_lamp_test (all segments on).
module seg7_mux_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned CLK_FREQ_HZ  = 12_500_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned PWM_BITS     = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
`ifdef SEG7_LAMP_TEST_EN
    input  logic                    i_lamp_test,
`endif
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic [PWM_BITS-1:0]     i_brightness,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic                    o_frame_start
);

    localparam int unsigned SLOT = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int unsigned CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    if (SLOT < BLANK_CYCLES + 2) begin : g_slot_check
        $error("seg7_mux_ctrl: slot of %0d cycles too short for %0d blank cycles", SLOT, BLANK_CYCLES);
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_digit_check
        $error("seg7_mux_ctrl: NUM_DIGITS must be 1..16");
    end

    // start_q marks the cycle after reset; the next edge opens frame 0.
    logic                    start_q;
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PWM_BITS-1:0]     pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [PWM_BITS-1:0]     sh_bright_q, sh_bright_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fs_q;
    logic                    frame_entry;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;

    seg7_hex_decode u_dec (
        .hex_i (nib),
        .seg_o (seg_dec)
    );

    // Next-state: slot counter, digit index, phase, PWM, shadows and outputs.
    // Outputs are derived from the next-state values so they move on the
    // same edge as the FSM with no extra pipeline stage.
    always_comb begin
        frame_entry = 1'b0;
        idx_d       = idx_q;
        cnt_d       = cnt_q + 1'b1;
        if (start_q) begin
            frame_entry = 1'b1;
            idx_d       = '0;
            cnt_d       = '0;
        end else if (cnt_q == SLOT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d       = '0;
                frame_entry = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        state_d = state_q;
        pwm_d   = pwm_q;
        if (cnt_d == BLANK_END) begin
            state_d = S_ON;
            pwm_d   = '0;
        end else if (cnt_d == '0) begin
            state_d = S_BLANK;
        end else if (state_q == S_ON) begin
            pwm_d = pwm_q + 1'b1;
        end

        sh_digits_d = frame_entry ? i_digits     : sh_digits_q;
        sh_dp_d     = frame_entry ? i_dp         : sh_dp_q;
        sh_en_d     = frame_entry ? i_digit_en   : sh_en_q;
        sh_bright_d = frame_entry ? i_brightness : sh_bright_q;

        nib   = sh_digits_d[{idx_d, 2'b00} +: 4];
        seg_d = seg_dec;
        dp_d  = ~sh_dp_d[idx_d];
`ifdef SEG7_LAMP_TEST_EN
        if (i_lamp_test && sh_en_d[idx_d]) begin
            seg_d = '0;
            dp_d  = 1'b0;
        end
`endif
        an_d = '1;
        if (state_d == S_ON && sh_en_d[idx_d] && pwm_d <= sh_bright_d) begin
            an_d[idx_d] = 1'b0;
        end
    end

    // State, shadow and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b1;
            state_q     <= S_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            sh_bright_q <= '0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            fs_q        <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_en_q     <= sh_en_d;
            sh_bright_q <= sh_bright_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            fs_q        <= frame_entry;
        end
    end

    assign o_an          = an_q;
    assign o_seg         = seg_q;
    assign o_dp          = dp_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// tb_seg7_mux_ctrl: directed, table-driven bench for seg7_mux_ctrl
// (4 digits, 20-cycle slots, 4 blank cycles, 4-bit PWM, 80-cycle frames).
module tb_seg7_mux_ctrl;

    localparam int ND    = 4;
    localparam int SLOTC = 20;
    localparam int BLK   = 4;
    localparam int FRAME = ND * SLOTC;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_digits;
    logic [3:0]  i_dp;
    logic [3:0]  i_digit_en;
    logic [3:0]  i_brightness;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame_start;
`ifdef SEG7_LAMP_TEST_EN
    logic        i_lamp_test = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_mux_ctrl #(
        .NUM_DIGITS   (4),
        .CLK_FREQ_HZ  (800),
        .REFRESH_HZ   (10),
        .BLANK_CYCLES (4),
        .PWM_BITS     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef SEG7_LAMP_TEST_EN
        .i_lamp_test   (i_lamp_test),
`endif
        .i_digits      (i_digits),
        .i_dp          (i_dp),
        .i_digit_en    (i_digit_en),
        .i_brightness  (i_brightness),
        .o_an          (o_an),
        .o_seg         (o_seg),
        .o_dp          (o_dp),
        .o_frame_start (o_frame_start)
    );

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic [3:0]      bright;
        int              nframes;
        int              chg_t;      // frame cycle at which i_digits changes, -1 = none
        logic [15:0]     chg_digits;
        logic [3:0][6:0] seg;        // expected o_seg per digit slot
        logic [3:0]      exp_dp;     // expected o_dp per digit slot
        logic [3:0][4:0] on_cnt;     // expected anode-low cycles per digit
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int vi);
        i_digits     = vecs[vi].digits;
        i_dp         = vecs[vi].dp;
        i_digit_en   = vecs[vi].en;
        i_brightness = vecs[vi].bright;
    endtask

    task automatic wait_fs();
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (o_frame_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_frame_start: got no pulse expected pulse within 200 cycles");
        end
    endtask

    // Called at the negedge showing o_frame_start; returns at the next one.
    task automatic run_frame(input int vi);
        int low [4];
        int seg_bad [4];
        int dp_bad [4];
        int blank_bad = 0;
        int multi_bad = 0;
        int fs_bad = 0;
        for (int k = 0; k < 4; k++) begin
            low[k] = 0; seg_bad[k] = 0; dp_bad[k] = 0;
        end
        for (int t = 0; t < FRAME; t++) begin
            int k = t / SLOTC;
            int pos = t % SLOTC;
            if (pos < BLK && o_an !== 4'hF) blank_bad++;
            if ($countones(~o_an) > 1) multi_bad++;
            for (int j = 0; j < 4; j++) begin
                if (o_an[j] === 1'b0) begin
                    if (j == k) low[k]++;
                    else multi_bad++;
                end
            end
            if (o_seg !== vecs[vi].seg[k]) seg_bad[k]++;
            if (o_dp !== vecs[vi].exp_dp[k]) dp_bad[k]++;
            if (t > 0 && o_frame_start) fs_bad++;
            if (vecs[vi].chg_t == t) i_digits = vecs[vi].chg_digits;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("v%0d_on_cycles_d%0d", vi, k), low[k], vecs[vi].on_cnt[k]);
            chk($sformatf("v%0d_seg_errs_d%0d", vi, k), seg_bad[k], 0);
            chk($sformatf("v%0d_dp_errs_d%0d", vi, k), dp_bad[k], 0);
        end
        chk($sformatf("v%0d_blank_errs", vi), blank_bad, 0);
        chk($sformatf("v%0d_multi_anode_errs", vi), multi_bad, 0);
        chk($sformatf("v%0d_early_frame_start", vi), fs_bad, 0);
        chk($sformatf("v%0d_frame_period", vi), o_frame_start, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{digits: 16'h3210, dp: 4'h0, en: 4'hF, bright: 4'hF, nframes: 1, chg_t: -1,
                    chg_digits: 16'h0,
                    seg: {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001},
                    exp_dp: 4'hF, on_cnt: {5'd16, 5'd16, 5'd16, 5'd16}};
        vecs[1] = '{digits: 16'hA987, dp: 4'b1010, en: 4'hF, bright: 4'h3, nframes: 1, chg_t: -1,
                    chg_digits: 16'h0,
                    seg: {7'b0001000, 7'b0000100, 7'b0000000, 7'b0001111},
                    exp_dp: 4'b0101, on_cnt: {5'd4, 5'd4, 5'd4, 5'd4}};
        vecs[2] = '{digits: 16'hFEDC, dp: 4'h0, en: 4'hF, bright: 4'h0, nframes: 1, chg_t: -1,
                    chg_digits: 16'h0,
                    seg: {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001},
                    exp_dp: 4'hF, on_cnt: {5'd1, 5'd1, 5'd1, 5'd1}};
        vecs[3] = '{digits: 16'h6B45, dp: 4'hF, en: 4'b0101, bright: 4'hF, nframes: 10, chg_t: -1,
                    chg_digits: 16'h0,
                    seg: {7'b0100000, 7'b1100000, 7'b1001100, 7'b0100100},
                    exp_dp: 4'h0, on_cnt: {5'd0, 5'd16, 5'd0, 5'd16}};
        vecs[4] = '{digits: 16'h3210, dp: 4'h0, en: 4'hF, bright: 4'h7, nframes: 1, chg_t: 45,
                    chg_digits: 16'hFFFF,
                    seg: {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001},
                    exp_dp: 4'hF, on_cnt: {5'd8, 5'd8, 5'd8, 5'd8}};

        rst = 1'b1;
        i_digits = '0; i_dp = '0; i_digit_en = '0; i_brightness = '0;

        // reset held three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_an", o_an, 4'hF);
            chk("rst_seg", o_seg, 7'h7F);
            chk("rst_dp", o_dp, 1'b1);
            chk("rst_frame_start", o_frame_start, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_frame_start", o_frame_start, 1'b1);
        chk("first_blank_an", o_an, 4'hF);

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            apply(v);
            @(negedge clk);
            wait_fs();
            for (int f = 0; f < vecs[v].nframes; f++) run_frame(v);
            if (vecs[v].chg_t >= 0) chk("post_change_seg_d0", o_seg, 7'b0111000);
        end

        // reset pulse in the ON phase of digit 2
        apply(0);
        @(negedge clk);
        wait_fs();
        repeat (50) @(negedge clk);
        chk("midslot_an_d2", o_an, 4'b1011);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", o_an, 4'hF);
        chk("midrst_seg", o_seg, 7'h7F);
        chk("midrst_dp", o_dp, 1'b1);
        chk("midrst_frame_start", o_frame_start, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_frame_start", o_frame_start, 1'b1);
        chk("restart_an", o_an, 4'hF);
        chk("restart_seg_d0", o_seg, 7'b0000001);
        run_frame(0);

`ifdef SEG7_LAMP_TEST_EN
        i_lamp_test = 1'b1;
        repeat (5) @(negedge clk);
        chk("lamp_seg", o_seg, 7'h00);
        chk("lamp_dp", o_dp, 1'b0);
        chk("lamp_an", o_an, 4'b1110);
        i_lamp_test = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
